// File: rtl/instruction_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_pkg : shared constants for the fetch stage
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package instruction_fetch_pkg;

  localparam int          XLEN_DEFAULT = 32;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

  localparam logic [1:0]  IDLE = 2'd0;
  localparam logic [1:0]  REQ  = 2'd1;
  localparam logic [1:0]  WAIT = 2'd2;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_if : instruction memory req/gnt + rvalid bus
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface instruction_fetch_if #(
  parameter int XLEN = 32
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch : PC holder and single-outstanding fetch to decode
// Optional: ROCKWAVE_FETCH_MISALIGN_CHECK_EN traps misaligned fetch addresses
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            phase_fetch,
  input  wire logic            pc_we,
  input  wire logic [XLEN-1:0] pc_next_wb,
  instruction_fetch_if.master  imem,
  output logic [31:0]          inst,
  output logic [XLEN-1:0]      curr_pc_fd,
  output logic [XLEN-1:0]      next_pc_fd,
  output logic                 stall_fetch,
  output logic                 inst_misalign
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [1:0]      state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pend_pc;
  logic            pend_we;
  logic [XLEN-1:0] start_addr;
  logic            start_misalign;
  logic            bypass;
  logic            capture;

  assign start_addr  = pc_we ? pc_next_wb : pc;
  assign stall_fetch = (state != IDLE);
  assign capture     = (state == WAIT) && (imem.imem_rvalid || bypass);

`ifdef ROCKWAVE_FETCH_MISALIGN_CHECK_EN
  assign start_misalign = (start_addr[1:0] != 2'b00);

  // bypass marks a WAIT entered without a memory request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bypass        <= 1'b0;
      inst_misalign <= 1'b0;
    end else begin
      if (state == IDLE && phase_fetch)
        bypass <= start_misalign;
      else if (capture)
        bypass <= 1'b0;
      if (capture)
        inst_misalign <= bypass;
    end
  end
`else
  assign start_misalign = 1'b0;
  assign bypass         = 1'b0;
  assign inst_misalign  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= RESET_VECTOR;
      fetch_pc       <= '0;
      pend_pc        <= '0;
      pend_we        <= 1'b0;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= '0;
      inst           <= INST_NOP;
      curr_pc_fd     <= '0;
      next_pc_fd     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_we)
            pc <= pc_next_wb;
          if (phase_fetch) begin
            fetch_pc <= start_addr;
            if (start_misalign) begin
              state <= WAIT;
            end else begin
              state          <= REQ;
              imem.imem_req  <= 1'b1;
              imem.imem_addr <= {start_addr[XLEN-1:2], 2'b00};
            end
          end
        end
        REQ: begin
          if (imem.imem_gnt) begin
            imem.imem_req <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (capture)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Redirects arriving mid-fetch are deferred; the last one wins
      if (state != IDLE && pc_we) begin
        pend_pc <= pc_next_wb;
        pend_we <= 1'b1;
      end

      if (capture) begin
        inst       <= bypass ? INST_NOP : imem.imem_rdata;
        curr_pc_fd <= fetch_pc;
        next_pc_fd <= fetch_pc + PC_STEP;
        if (pc_we)
          pc <= pc_next_wb;
        else if (pend_we)
          pc <= pend_pc;
        pend_we <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch : randomized scoreboard bench for instruction_fetch
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            phase_fetch = 1'b0;
  logic            pc_we = 1'b0;
  logic [XLEN-1:0] pc_next_wb = '0;
  logic [31:0]     inst;
  logic [XLEN-1:0] curr_pc_fd;
  logic [XLEN-1:0] next_pc_fd;
  logic            stall_fetch;
  logic            inst_misalign;

  instruction_fetch_if #(.XLEN(XLEN)) imem_bus ();

  instruction_fetch #(.XLEN(XLEN), .RESET_VECTOR(32'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .phase_fetch  (phase_fetch),
    .pc_we        (pc_we),
    .pc_next_wb   (pc_next_wb),
    .imem         (imem_bus),
    .inst         (inst),
    .curr_pc_fd   (curr_pc_fd),
    .next_pc_fd   (next_pc_fd),
    .stall_fetch  (stall_fetch),
    .inst_misalign(inst_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] curr;
    logic [31:0] next;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_pc = 32'h0;
  logic [31:0] exp_req_addr = 32'h0;
  logic [31:0] hold_inst = INST_NOP;
  logic [31:0] hold_curr = 32'h0;
  int          gnt_min = 0, gnt_max = 0, rv_min = 0, rv_max = 0;
  bit          spurious_en = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: random grant and response delays, optional stray rvalid
  initial begin
    bit          pend = 1'b0;
    bit          armed = 1'b0;
    int          gcnt = 0;
    int          rcnt = 0;
    logic [31:0] raddr = 32'h0;
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = 32'h0;
    forever begin
      @(posedge clk); #1;
      imem_bus.imem_gnt    = 1'b0;
      imem_bus.imem_rvalid = 1'b0;
      if (!rst_n) begin
        armed = 1'b0;
      end else if (pend) begin
        if (rcnt == 0) begin
          imem_bus.imem_rvalid = 1'b1;
          imem_bus.imem_rdata  = mem_word(raddr);
          pend = 1'b0;
        end else begin
          rcnt--;
        end
      end else if (imem_bus.imem_req) begin
        if (!armed) begin
          gcnt  = $urandom_range(gnt_max, gnt_min);
          armed = 1'b1;
        end
        check("imem_addr", imem_bus.imem_addr, exp_req_addr);
        if (gcnt == 0) begin
          imem_bus.imem_gnt = 1'b1;
          raddr = imem_bus.imem_addr;
          pend  = 1'b1;
          rcnt  = $urandom_range(rv_max, rv_min);
          armed = 1'b0;
        end else begin
          gcnt--;
          if (spurious_en && $urandom_range(1, 0) == 1) begin
            imem_bus.imem_rvalid = 1'b1;
            imem_bus.imem_rdata  = $urandom;
          end
        end
      end
    end
  end

  // Monitor: a completed fetch is a falling stall_fetch outside reset
  initial begin
    bit   ps = 1'b0;
    bit   pr = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && pr && ps && !stall_fetch) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_completion: got inst %h expected no completion", inst);
        end else begin
          e = exp_q.pop_front();
          check("inst", inst, e.inst);
          check("curr_pc_fd", curr_pc_fd, e.curr);
          check("next_pc_fd", next_pc_fd, e.next);
          check("inst_misalign", {31'b0, inst_misalign}, {31'b0, e.mis});
          hold_inst = e.inst;
          hold_curr = e.curr;
        end
      end
      ps = stall_fetch;
      pr = rst_n;
    end
  end

  // busy_mode: 0 quiet, 1 random redirects/strobes, 2 redirect 0x200 then 0x300 in WAIT
  task automatic do_fetch(input bit with_we, input logic [31:0] we_val,
                          input int busy_mode, output int stall_cycles);
    exp_t        e;
    logic [31:0] addr;
    int          n = 0;
    int          budget = 0;
    @(posedge clk); #1;
    phase_fetch = 1'b1;
    pc_we       = with_we;
    pc_next_wb  = we_val;
    if (with_we) model_pc = we_val;
    addr   = model_pc;
    e.inst = mem_word(addr & 32'hFFFF_FFFC);
    e.curr = addr;
    e.next = addr + 32'd4;
    e.mis  = 1'b0;
`ifdef ROCKWAVE_FETCH_MISALIGN_CHECK_EN
    if (addr[1:0] != 2'b00) begin
      e.inst = INST_NOP;
      e.mis  = 1'b1;
    end
`endif
    exp_q.push_back(e);
    exp_req_addr = addr & 32'hFFFF_FFFC;
    stall_cycles = 0;
    forever begin
      @(posedge clk); #1;
      phase_fetch = 1'b0;
      pc_we       = 1'b0;
      if (!stall_fetch) break;
      stall_cycles++;
      check("hold_inst", inst, hold_inst);
      check("hold_curr", curr_pc_fd, hold_curr);
      if (busy_mode == 1) begin
        if ($urandom_range(3, 0) == 0) begin
          pc_we      = 1'b1;
          pc_next_wb = $urandom & 32'hFFFF_FFFC;
          model_pc   = pc_next_wb;
        end
        if ($urandom_range(3, 0) == 0) phase_fetch = 1'b1;
      end else if (busy_mode == 2 && !imem_bus.imem_req && n < 2) begin
        pc_we      = 1'b1;
        pc_next_wb = (n == 0) ? 32'h200 : 32'h300;
        model_pc   = pc_next_wb;
        n++;
      end
      budget++;
      if (budget > 60) begin
        checks++;
        failures++;
        $display("FAIL fetch_timeout: got stall after %0d cycles expected completion", budget);
        break;
      end
    end
  endtask

  initial begin
    int sc;
    repeat (3) @(posedge clk);
    #1;
    check("rst_inst", inst, INST_NOP);
    check("rst_curr", curr_pc_fd, 32'h0);
    check("rst_next", next_pc_fd, 32'h0);
    check("rst_stall", {31'b0, stall_fetch}, 32'h0);
    check("rst_req", {31'b0, imem_bus.imem_req}, 32'h0);
    check("rst_addr", imem_bus.imem_addr, 32'h0);
    check("rst_misalign", {31'b0, inst_misalign}, 32'h0);
    rst_n = 1'b1;

    // Minimum latency fetch from the reset vector
    do_fetch(1'b0, 32'h0, 0, sc);
    check("min_stall_cycles", sc, 2);
    check("first_inst", inst, 32'h0050_0093);
    check("first_next", next_pc_fd, 32'h4);

    // Slow grant and slow response
    gnt_min = 3; gnt_max = 3; rv_min = 1; rv_max = 1;
    do_fetch(1'b0, 32'h0, 0, sc);
    check("slow_stall_cycles", sc, 6);

    // Redirect in the same cycle as the fetch strobe
    gnt_min = 0; gnt_max = 0; rv_min = 0; rv_max = 0;
    do_fetch(1'b1, 32'h100, 0, sc);
    check("redirect_curr", curr_pc_fd, 32'h100);

    // Two redirects during WAIT: in-flight uses old PC, next uses the last
    rv_min = 3; rv_max = 3;
    do_fetch(1'b0, 32'h0, 2, sc);
    check("pend_old_curr", curr_pc_fd, 32'h100);
    rv_min = 0; rv_max = 0;
    do_fetch(1'b0, 32'h0, 0, sc);
    check("pend_new_curr", curr_pc_fd, 32'h300);

    // PC+4 wraps at the top of the address space
    do_fetch(1'b1, 32'hFFFF_FFFC, 0, sc);
    check("wrap_next", next_pc_fd, 32'h0);

    // Misaligned fetch address
    do_fetch(1'b1, 32'h102, 0, sc);
`ifdef ROCKWAVE_FETCH_MISALIGN_CHECK_EN
    check("mis_flag", {31'b0, inst_misalign}, 32'h1);
    check("mis_inst", inst, INST_NOP);
    check("mis_stall_cycles", sc, 1);
`else
    check("mis_flag", {31'b0, inst_misalign}, 32'h0);
`endif
    do_fetch(1'b1, 32'h40, 0, sc);
    check("mis_cleared", {31'b0, inst_misalign}, 32'h0);

    // Randomized traffic
    gnt_max = 3; rv_max = 3; spurious_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int idle = $urandom_range(3, 0);
      for (int k = 0; k < idle; k++) begin
        @(posedge clk); #1;
        pc_we = 1'b0;
        if ($urandom_range(2, 0) == 0) begin
          pc_we      = 1'b1;
          pc_next_wb = $urandom & 32'hFFFF_FFFC;
          model_pc   = pc_next_wb;
        end
      end
      do_fetch(1'($urandom_range(1, 0)), $urandom & 32'hFFFF_FFFC, 1, sc);
    end

    // Reset while waiting for the response; the late rvalid must be ignored
    spurious_en = 1'b0; gnt_min = 0; gnt_max = 0; rv_min = 3; rv_max = 3;
    @(posedge clk); #1;
    exp_req_addr = model_pc & 32'hFFFF_FFFC;
    phase_fetch  = 1'b1;
    @(posedge clk); #1;
    phase_fetch = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_wait", {30'b0, stall_fetch, imem_bus.imem_req}, 32'h2);
    rst_n = 1'b0;
    #1;
    model_pc  = 32'h0;
    hold_inst = INST_NOP;
    hold_curr = 32'h0;
    check("mid_rst_stall", {31'b0, stall_fetch}, 32'h0);
    check("mid_rst_req", {31'b0, imem_bus.imem_req}, 32'h0);
    check("mid_rst_inst", inst, INST_NOP);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("late_rv_inst", inst, INST_NOP);
    check("late_rv_curr", curr_pc_fd, 32'h0);
    check("late_rv_next", next_pc_fd, 32'h0);
    check("late_rv_stall", {31'b0, stall_fetch}, 32'h0);

    rv_min = 0; rv_max = 0;
    do_fetch(1'b0, 32'h0, 0, sc);
    check("post_rst_inst", inst, 32'h0050_0093);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected $finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
